// File: rtl/frame_merge.sv
// Round-robin, frame-locked merge of the ARP/ICMP/UDP transmit streams onto one MAC byte stream.
// Latency: one cycle from request to first beat, then zero-latency pass-through; the MAC's ready backpressures the granted source only.
module frame_merge #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic        logic_clk,
    input  logic        logic_rstn,
    input  logic [7:0]  arp_tdata_in,
    input  logic        arp_tvalid_in,
    output logic        arp_tready_out,
    input  logic        arp_tlast_in,
    input  logic [31:0] arp_tip_in,
    input  logic [7:0]  icmp_tdata_in,
    input  logic        icmp_tvalid_in,
    output logic        icmp_tready_out,
    input  logic        icmp_tlast_in,
    input  logic [31:0] icmp_tip_in,
    input  logic [7:0]  udp_tdata_in,
    input  logic        udp_tvalid_in,
    output logic        udp_tready_out,
    input  logic        udp_tlast_in,
    input  logic [31:0] udp_tip_in,
    output logic [7:0]  net_tmac_data_out,
    output logic        net_tmac_valid_out,
    input  logic        net_tmac_ready_in,
    output logic        net_tmac_last_out,
    output logic [34:0] net_tmac_type_out,
    output logic        busy_out,
    output logic        abort_out
);

    typedef enum logic [1:0] {IDLE, XFER, ABORT, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;   // 0 = ARP, 1 = ICMP, 2 = UDP
    logic [1:0]  rr_q, rr_d;         // first source examined by the next search
    logic [34:0] type_q, type_d;
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        abort_q, abort_d;

    // Slot 3 is padding so a 2-bit index never leaves the vector.
    logic [3:0]       src_vld;
    logic [3:0]       src_lst;
    logic [3:0][7:0]  src_dat;
    logic [3:0][31:0] src_ip;

    assign src_vld = {1'b0, udp_tvalid_in, icmp_tvalid_in, arp_tvalid_in};
    assign src_lst = {1'b0, udp_tlast_in, icmp_tlast_in, arp_tlast_in};
    assign src_dat = {8'h00, udp_tdata_in, icmp_tdata_in, arp_tdata_in};
    assign src_ip  = {32'h0, udp_tip_in, icmp_tip_in, arp_tip_in};

    function automatic logic [1:0] rr_next(input logic [1:0] s);
        return (s >= 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    function automatic logic [2:0] type_code(input logic [1:0] s);
        case (s)
            2'd0:    return 3'b001;
            2'd1:    return 3'b100;
            2'd2:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    logic [1:0] cand1, cand2, pick;
    logic       g_vld, g_lst;
    logic [7:0] g_dat;

    always_comb begin
        cand1 = rr_next(rr_q);
        cand2 = rr_next(cand1);
        pick  = rr_q;
        if (src_vld[rr_q])       pick = rr_q;
        else if (src_vld[cand1]) pick = cand1;
        else if (src_vld[cand2]) pick = cand2;
        g_vld = src_vld[grant_q];
        g_lst = src_lst[grant_q];
        g_dat = src_dat[grant_q];
    end

    always_ff @(posedge logic_clk) begin
        if (!logic_rstn) begin
            state_q  <= IDLE;
            grant_q  <= 2'd0;
            rr_q     <= 2'd0;
            type_q   <= 35'h0;
            wd_cnt_q <= 16'h0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            type_q   <= type_d;
            wd_cnt_q <= wd_cnt_d;
            abort_q  <= abort_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        type_d   = type_q;
        wd_cnt_d = wd_cnt_q;
        abort_d  = 1'b0;
        case (state_q)
            IDLE: begin
                wd_cnt_d = 16'h0;
                if (|src_vld[2:0]) begin
                    state_d = XFER;
                    grant_d = pick;
                    rr_d    = rr_next(pick);
                    type_d  = {src_ip[pick], type_code(pick)};
                end
            end
            XFER: begin
                if (g_vld) begin
                    wd_cnt_d = 16'h0;
                    if (net_tmac_ready_in && g_lst) state_d = IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
                    if (TIMEOUT_CYCLES != 16'd0 && wd_cnt_d == TIMEOUT_CYCLES) begin
                        state_d  = ABORT;
                        abort_d  = 1'b1;
                        wd_cnt_d = 16'h0;
                    end
                end
            end
            ABORT: begin
                if (net_tmac_ready_in) state_d = DRAIN;
            end
            DRAIN: begin
                if (g_vld && g_lst) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic [2:0] grant_oh;
    logic [2:0] rdy_vec;

    always_comb begin
        grant_oh           = 3'b001 << grant_q;
        rdy_vec            = 3'b000;
        net_tmac_data_out  = 8'h00;
        net_tmac_valid_out = 1'b0;
        net_tmac_last_out  = 1'b0;
        case (state_q)
            XFER: begin
                net_tmac_data_out  = g_dat;
                net_tmac_valid_out = g_vld;
                net_tmac_last_out  = g_lst;
                rdy_vec            = grant_oh & {3{net_tmac_ready_in}};
            end
            ABORT: begin
                // Terminating beat so the MAC closes the truncated frame.
                net_tmac_valid_out = 1'b1;
                net_tmac_last_out  = 1'b1;
            end
            DRAIN: rdy_vec = grant_oh;
            default: ;
        endcase
    end

    assign arp_tready_out    = rdy_vec[0];
    assign icmp_tready_out   = rdy_vec[1];
    assign udp_tready_out    = rdy_vec[2];
    assign net_tmac_type_out = type_q;
    assign busy_out          = (state_q != IDLE);
    assign abort_out         = abort_q;

endmodule

// File: tb/tb_frame_merge.sv
// Directed-vector bench for frame_merge: inputs change 1 ns after the rising edge, outputs are checked on the falling edge.
module tb_frame_merge;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  arp_dat, icmp_dat, udp_dat, mac_dat;
    logic        arp_vld, icmp_vld, udp_vld, mac_vld;
    logic        arp_rdy, icmp_rdy, udp_rdy, mac_rdy;
    logic        arp_lst, icmp_lst, udp_lst, mac_lst;
    logic [31:0] arp_tip, icmp_tip, udp_tip;
    logic [34:0] mac_type;
    logic        busy, abort_p;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    frame_merge #(.TIMEOUT_CYCLES(16'd8)) dut (
        .logic_clk(clk), .logic_rstn(rstn),
        .arp_tdata_in(arp_dat), .arp_tvalid_in(arp_vld), .arp_tready_out(arp_rdy),
        .arp_tlast_in(arp_lst), .arp_tip_in(arp_tip),
        .icmp_tdata_in(icmp_dat), .icmp_tvalid_in(icmp_vld), .icmp_tready_out(icmp_rdy),
        .icmp_tlast_in(icmp_lst), .icmp_tip_in(icmp_tip),
        .udp_tdata_in(udp_dat), .udp_tvalid_in(udp_vld), .udp_tready_out(udp_rdy),
        .udp_tlast_in(udp_lst), .udp_tip_in(udp_tip),
        .net_tmac_data_out(mac_dat), .net_tmac_valid_out(mac_vld),
        .net_tmac_ready_in(mac_rdy), .net_tmac_last_out(mac_lst),
        .net_tmac_type_out(mac_type), .busy_out(busy), .abort_out(abort_p)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        @(negedge clk);
        total++;
        if ({arp_rdy, icmp_rdy, udp_rdy} !== 3'b000)
            begin bad++; $display("FAIL reset_readies got=%b exp=000", {arp_rdy, icmp_rdy, udp_rdy}); end
        total++;
        if ({mac_vld, mac_lst, busy, abort_p} !== 4'b0000)
            begin bad++; $display("FAIL reset_flags vld/lst/busy/abort got=%b exp=0000", {mac_vld, mac_lst, busy, abort_p}); end
        total++;
        if (mac_dat !== 8'h00 || mac_type !== 35'h0)
            begin bad++; $display("FAIL reset_data got=%h/%h exp=00/0", mac_dat, mac_type); end
        tick();
    endtask

    task automatic test_arp_frame();
        arp_tip = 32'hC0A8_0A01;
        arp_vld = 1'b1; arp_dat = 8'h01; arp_lst = 1'b0; mac_rdy = 1'b1;
        @(negedge clk);
        total++;
        if (mac_vld !== 1'b0) begin bad++; $display("FAIL arp_req_latency got=%b exp=0", mac_vld); end
        tick();
        for (int i = 1; i <= 28; i++) begin
            @(negedge clk);
            total++;
            if (mac_vld !== 1'b1 || mac_dat !== i[7:0] || mac_lst !== (i == 28) || arp_rdy !== 1'b1)
                begin bad++; $display("FAIL arp_beat%0d got=v%b d%h l%b r%b exp=v1 d%h l%b r1", i, mac_vld, mac_dat, mac_lst, arp_rdy, i[7:0], (i == 28)); end
            if (i == 1) begin
                total++;
                if (mac_type !== {32'hC0A8_0A01, 3'b001})
                    begin bad++; $display("FAIL arp_type got=%h exp=%h", mac_type, {32'hC0A8_0A01, 3'b001}); end
            end
            tick();
            if (i < 28) begin arp_dat = arp_dat + 8'd1; arp_lst = (i + 1 == 28); end
            else begin arp_vld = 1'b0; arp_lst = 1'b0; end
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL arp_busy_fall got=%b exp=0", busy); end
        tick();
    endtask

    task automatic test_simultaneous();
        logic [7:0]  base  [3];
        logic [31:0] tips  [3];
        logic [2:0]  codes [3];
        int idx [3];
        logic acc [3];
        logic [7:0] exp_d;
        int ph, fr;
        base[0] = 8'h10; base[1] = 8'h20; base[2] = 8'h30;
        tips[0] = 32'h0A00_0001; tips[1] = 32'h0A00_0002; tips[2] = 32'h0A00_0003;
        codes[0] = 3'b001; codes[1] = 3'b100; codes[2] = 3'b010;
        arp_tip = tips[0]; icmp_tip = tips[1]; udp_tip = tips[2];
        idx[0] = 0; idx[1] = 0; idx[2] = 0;
        mac_rdy = 1'b1;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int c = 0; c < 15; c++) begin
            arp_vld  = (idx[0] < 4); arp_dat  = base[0] + idx[0][7:0]; arp_lst  = (idx[0] == 3);
            icmp_vld = (idx[1] < 4); icmp_dat = base[1] + idx[1][7:0]; icmp_lst = (idx[1] == 3);
            udp_vld  = (idx[2] < 4); udp_dat  = base[2] + idx[2][7:0]; udp_lst  = (idx[2] == 3);
            @(negedge clk);
            ph = c % 5;
            fr = c / 5;
            exp_d = base[fr] + ph[7:0] - 8'd1;
            total++;
            if (ph == 0) begin
                if (mac_vld !== 1'b0)
                    begin bad++; $display("FAIL rr_gap c%0d got vld=%b exp=0", c, mac_vld); end
            end else if (mac_vld !== 1'b1 || mac_dat !== exp_d || mac_lst !== (ph == 4) ||
                         mac_type !== {tips[fr], codes[fr]}) begin
                bad++;
                $display("FAIL rr_beat c%0d got=v%b d%h l%b t%h exp=v1 d%h l%b t%h", c, mac_vld, mac_dat,
                         mac_lst, mac_type, exp_d, (ph == 4), {tips[fr], codes[fr]});
            end
            acc[0] = arp_rdy & arp_vld; acc[1] = icmp_rdy & icmp_vld; acc[2] = udp_rdy & udp_vld;
            tick();
            for (int s = 0; s < 3; s++) if (acc[s]) idx[s]++;
        end
        arp_vld = 1'b0; icmp_vld = 1'b0; udp_vld = 1'b0;
        arp_lst = 1'b0; icmp_lst = 1'b0; udp_lst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || idx[2] != 4)
            begin bad++; $display("FAIL rr_end got busy=%b udp_beats=%0d exp busy=0 beats=4", busy, idx[2]); end
        tick();
    endtask

    task automatic test_toggle_ready();
        int got = 0;
        int cyc = 0;
        logic acc;
        udp_tip = 32'h0A00_0063;
        udp_vld = 1'b1; udp_dat = 8'hA0; udp_lst = 1'b0; mac_rdy = 1'b1;
        @(negedge clk);
        tick();
        while (got < 10 && cyc < 40) begin
            mac_rdy = (cyc % 2 == 0);
            @(negedge clk);
            total++;
            if (udp_rdy !== mac_rdy || mac_vld !== 1'b1)
                begin bad++; $display("FAIL tog_ready c%0d got rdy=%b vld=%b exp rdy=%b vld=1", cyc, udp_rdy, mac_vld, mac_rdy); end
            if (mac_rdy) begin
                total++;
                if (mac_dat !== 8'hA0 + got[7:0] || mac_lst !== (got == 9))
                    begin bad++; $display("FAIL tog_byte%0d got=%h l%b exp=%h l%b", got, mac_dat, mac_lst, 8'hA0 + got[7:0], (got == 9)); end
            end
            acc = mac_rdy;
            tick();
            if (acc) begin
                got++;
                udp_dat = 8'hA0 + got[7:0];
                udp_lst = (got == 9);
                if (got == 10) begin udp_vld = 1'b0; udp_lst = 1'b0; end
            end
            cyc++;
        end
        mac_rdy = 1'b1;
        total++;
        if (got != 10) begin bad++; $display("FAIL tog_count got=%0d exp=10", got); end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL tog_idle got busy=%b exp=0", busy); end
        tick();
    endtask

    task automatic test_abort();
        icmp_tip = 32'h0A00_0042;
        icmp_vld = 1'b1; icmp_dat = 8'h51; icmp_lst = 1'b0; mac_rdy = 1'b1;
        @(negedge clk);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (mac_vld !== 1'b1 || mac_dat !== 8'h51 + i[7:0])
                begin bad++; $display("FAIL abort_pre%0d got=v%b d%h exp=v1 d%h", i, mac_vld, mac_dat, 8'h51 + i[7:0]); end
            tick();
            icmp_dat = icmp_dat + 8'd1;
        end
        icmp_vld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (abort_p !== 1'b0 || mac_vld !== 1'b0 || busy !== 1'b1)
                begin bad++; $display("FAIL abort_starve%0d got abort=%b vld=%b busy=%b exp 0/0/1", i, abort_p, mac_vld, busy); end
            tick();
        end
        @(negedge clk);
        total++;
        if (abort_p !== 1'b1 || mac_vld !== 1'b1 || mac_dat !== 8'h00 || mac_lst !== 1'b1 || icmp_rdy !== 1'b0)
            begin bad++; $display("FAIL abort_beat got a%b v%b d%h l%b r%b exp a1 v1 d00 l1 r0", abort_p, mac_vld, mac_dat, mac_lst, icmp_rdy); end
        tick();
        icmp_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            icmp_dat = 8'h54 + i[7:0];
            icmp_lst = (i == 4);
            @(negedge clk);
            total++;
            if (abort_p !== 1'b0 || icmp_rdy !== 1'b1 || mac_vld !== 1'b0)
                begin bad++; $display("FAIL drain%0d got a%b r%b v%b exp a0 r1 v0", i, abort_p, icmp_rdy, mac_vld); end
            tick();
        end
        icmp_vld = 1'b0; icmp_lst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL drain_idle got busy=%b exp=0", busy); end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        udp_tip = 32'h0A00_0077;
        arp_tip = 32'h0A00_0011;
        udp_vld = 1'b1; udp_dat = 8'hC0; udp_lst = 1'b0; mac_rdy = 1'b1;
        @(negedge clk);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tick();
            udp_dat = udp_dat + 8'd1;
        end
        rstn = 1'b0;
        arp_vld = 1'b1; arp_dat = 8'hE0; arp_lst = 1'b1;
        @(negedge clk);
        tick();
        rstn = 1'b1;
        @(negedge clk);
        total++;
        if ({arp_rdy, icmp_rdy, udp_rdy} !== 3'b000 || mac_vld !== 1'b0 || busy !== 1'b0)
            begin bad++; $display("FAIL midrst_idle got rdy=%b vld=%b busy=%b exp 000/0/0", {arp_rdy, icmp_rdy, udp_rdy}, mac_vld, busy); end
        tick();
        @(negedge clk);
        total++;
        if (arp_rdy !== 1'b1 || udp_rdy !== 1'b0 || mac_dat !== 8'hE0 || mac_type !== {32'h0A00_0011, 3'b001})
            begin bad++; $display("FAIL midrst_arp_first got ar%b ur%b d%h t%h exp ar1 ur0 dE0 t%h", arp_rdy, udp_rdy, mac_dat, mac_type, {32'h0A00_0011, 3'b001}); end
        tick();
        arp_vld = 1'b0; arp_lst = 1'b0; udp_vld = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL single_beat_idle got busy=%b exp=0", busy); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0; mac_rdy = 1'b1;
        arp_dat = 8'h00; arp_vld = 1'b0; arp_lst = 1'b0; arp_tip = 32'h0;
        icmp_dat = 8'h00; icmp_vld = 1'b0; icmp_lst = 1'b0; icmp_tip = 32'h0;
        udp_dat = 8'h00; udp_vld = 1'b0; udp_lst = 1'b0; udp_tip = 32'h0;
        test_reset();
        test_arp_frame();
        test_simultaneous();
        test_toggle_ready();
        test_abort();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
